// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states and keyboard command/response bytes.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      REQ,
      DATA,
      PARITY,
      STOP,
      ACK,
      WAIT_IDLE
   } ps2_state_e;

   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] RSP_ACK     = 8'hFA;
   localparam logic [7:0] RSP_RESEND  = 8'hFE;
   localparam logic [7:0] BREAK       = 8'hF0;

endpackage

// File: rtl/ps2_sync.sv
// PS/2 line synchroniser: 3-flop clock shift with falling-edge pulse and a
// 2-flop data synchroniser. Shared with the keyboard receiver.
module ps2_sync (
   input  logic clk,
   input  logic clrn,
   input  logic ps2_clk_in,
   input  logic ps2_data_in,
   output logic clk_s,
   output logic data_s,
   output logic fall
);

   logic [2:0] clk_sr;
   logic [1:0] dat_sr;

   // Lines idle high, so the shift registers reset to all ones
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_sr <= 3'b111;
         dat_sr <= 2'b11;
      end else begin
         clk_sr <= {clk_sr[1:0], ps2_clk_in};
         dat_sr <= {dat_sr[0], ps2_data_in};
      end
   end

   assign clk_s  = clk_sr[1];
   assign data_s = dat_sr[1];
   assign fall   = clk_sr[2] & ~clk_sr[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 8 data bits LSB first,
// odd parity, stop, then device ACK check. Lines are driven open-drain via *_oe.
// Build option PS2_TX_RETRY_EN: re-send the byte once after an ACK error or timeout.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   ps2_state_e    state, nstate;
   logic [7:0]    shreg;
   logic          parity_q, data_q, ack_bad;
   logic [2:0]    bitcnt;
   logic [IW-1:0] inh_cnt;
   logic [TW-1:0] to_cnt;
   logic          clk_s, data_s, fall;
   logic          inh_last, in_frame, to_hit, line_idle, final_try, retry_go;

   ps2_sync u_sync (
      .clk         (clk),
      .clrn        (clrn),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_data_in (ps2_data_in),
      .clk_s       (clk_s),
      .data_s      (data_s),
      .fall        (fall)
   );

   assign inh_last  = (inh_cnt == IW'(INHIBIT_CYCLES - 1));
   assign in_frame  = (state != IDLE) && (state != INHIBIT);
   assign to_hit    = in_frame && (to_cnt == TW'(TIMEOUT_CYCLES));
   assign line_idle = clk_s & data_s;

`ifdef PS2_TX_RETRY_EN
   logic       retry_q;
   logic [7:0] byte_q;
   assign final_try = retry_q;
`else
   assign final_try = 1'b1;
`endif

   // An error on a non-final attempt restarts the frame instead of reporting
   assign retry_go = !final_try &&
                     (to_hit || (state == WAIT_IDLE && line_idle && ack_bad));

   // State register
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= IDLE;
      else       state <= nstate;
   end

   // Next state: timeout overrides every in-frame state
   always_comb begin
      nstate = state;
      if (to_hit) begin
         nstate = final_try ? IDLE : INHIBIT;
      end else begin
         case (state)
            IDLE:      if (tx_valid) nstate = INHIBIT;
            INHIBIT:   if (inh_last) nstate = REQ;
            REQ:       if (fall) nstate = DATA;
            DATA:      if (fall && bitcnt == 3'd6) nstate = PARITY;
            PARITY:    if (fall) nstate = STOP;
            STOP:      if (fall) nstate = ACK;
            ACK:       if (fall) nstate = WAIT_IDLE;
            WAIT_IDLE: if (line_idle) nstate = retry_go ? INHIBIT : IDLE;
            default:   nstate = IDLE;
         endcase
      end
   end

   // Outputs; the start bit overlaps the last inhibit cycle, and lines drop
   // in the same cycle the timeout is reported
   always_comb begin
      tx_ready    = (state == IDLE);
      busy        = (state != IDLE);
      ps2_clk_oe  = (state == INHIBIT);
      ps2_data_oe = (data_q && !to_hit) || (state == INHIBIT && inh_last);
      done        = (state == WAIT_IDLE) && line_idle && !to_hit && !retry_go;
      ack_err     = done && ack_bad;
      timeout_err = to_hit && final_try;
   end

   // Datapath: byte shift-out, bit counting, inhibit and timeout counters
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         shreg    <= '0;
         parity_q <= 1'b0;
         data_q   <= 1'b0;
         ack_bad  <= 1'b0;
         bitcnt   <= '0;
         inh_cnt  <= '0;
         to_cnt   <= '0;
`ifdef PS2_TX_RETRY_EN
         retry_q  <= 1'b0;
         byte_q   <= '0;
`endif
      end else begin
         if (in_frame && to_cnt != TW'(TIMEOUT_CYCLES)) to_cnt <= to_cnt + 1'b1;
         case (state)
            IDLE: begin
`ifdef PS2_TX_RETRY_EN
               retry_q <= 1'b0;
               if (tx_valid) byte_q <= tx_data;
`endif
               if (tx_valid) begin
                  shreg    <= tx_data;
                  parity_q <= ~^tx_data;
                  inh_cnt  <= '0;
                  ack_bad  <= 1'b0;
               end
            end
            INHIBIT: begin
               if (inh_last) begin
                  data_q <= 1'b1;
                  to_cnt <= '0;
               end else begin
                  inh_cnt <= inh_cnt + 1'b1;
               end
            end
            REQ: if (fall) begin
               data_q <= ~shreg[0];
               shreg  <= {1'b0, shreg[7:1]};
               bitcnt <= '0;
            end
            DATA: if (fall) begin
               data_q <= ~shreg[0];
               shreg  <= {1'b0, shreg[7:1]};
               bitcnt <= bitcnt + 1'b1;
            end
            PARITY:  if (fall) data_q <= ~parity_q;
            STOP:    if (fall) data_q <= 1'b0;
            ACK:     if (fall) ack_bad <= data_s;
            default: ;
         endcase
         if (to_hit) data_q <= 1'b0;
         if (retry_go) begin
            inh_cnt <= '0;
            ack_bad <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            shreg   <= byte_q;
            retry_q <= 1'b1;
`endif
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: device model on the open-drain lines, scoreboard
// queue of expected frame outcomes, independent monitor. Honours PS2_TX_RETRY_EN.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INHIB = 20;
   localparam int TMO   = 2000;
   localparam int HALF  = 15;
`ifdef PS2_TX_RETRY_EN
   localparam bit RETRY = 1'b1;
`else
   localparam bit RETRY = 1'b0;
`endif

   logic       clk = 1'b0, clrn = 1'b0, tx_valid = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_ready, busy, done, ack_err, timeout_err;
   logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
   logic       dev_clk = 1'b1, dev_data = 1'b1;

   // wired-AND open-drain lines
   assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
   assign ps2_data_in = ~ps2_data_oe & dev_data;

   ps2_host_tx #(.INHIBIT_CYCLES(INHIB), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .clrn(clrn), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_ready(tx_ready), .busy(busy), .done(done), .ack_err(ack_err),
      .timeout_err(timeout_err), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] b;
      bit         to;
      bit         ack_bad;
   } exp_t;

   exp_t       exp_q[$];
   logic [9:0] cap_q[$];
   int pass_cnt = 0, total_cnt = 0;
   int done_cnt = 0, inh_starts = 0, inv_bad = 0, cyc = 0, req_cyc = 0, run = 0;
   bit ready_pend = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total_cnt++;
      if (act === expv) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Watcher: inhibit length, REQ entry time, standing invariants
   always @(negedge clk) begin
      if (!clrn) run = 0;
      else begin
         if (ps2_clk_oe) begin
            if (run == 0) inh_starts++;
            run++;
         end else if (run > 0) begin
            check("inhibit_len", run, INHIB);
            req_cyc = cyc;
            run = 0;
         end
         if (tx_ready == busy) inv_bad++;
         if (ack_err && !done) inv_bad++;
         if (timeout_err && done) inv_bad++;
      end
   end

   // Monitor: pops the scoreboard whenever a frame ends
   always @(negedge clk) begin
      exp_t       e;
      logic [9:0] c, mdl;
      bit         par;
      if (ready_pend) begin
         check("ready_after_end", tx_ready, 1);
         ready_pend = 1'b0;
      end
      if (clrn && (done || timeout_err)) begin
         if (done) done_cnt++;
         if (exp_q.size() == 0) check("unexpected_end", 0, 1);
         else begin
            e = exp_q.pop_front();
            check("end_is_timeout", timeout_err, e.to);
            check("end_is_done", done, !e.to);
            if (e.to) begin
               check("timeout_cycle", cyc - req_cyc, TMO);
               check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
            end else begin
               check("ack_err", ack_err, e.ack_bad);
               if (cap_q.size() == 0) check("line_bits_present", 0, 1);
               else begin
                  c   = cap_q.pop_front();
                  par = ($countones(e.b) % 2 == 0);
                  mdl = {1'b1, par, e.b};
                  check("line_bits", c, mdl);
               end
            end
            ready_pend = 1'b1;
         end
      end
   end

   // Keyboard model: waits for request-to-send, clocks nclk bits, answers ACK
   task automatic device_frame(input int nclk, input bit ack_bit, input bit keep);
      logic [9:0] cap = '0;
      int n = 0;
      while (!ps2_clk_oe && n < 300) begin @(negedge clk); n++; end
      if (!ps2_clk_oe) begin check("rts_seen", 0, 1); return; end
      n = 0;
      while (ps2_clk_oe && n < 300) begin @(negedge clk); n++; end
      check("start_bit", ps2_data_oe, 1);
      repeat (10) @(negedge clk);
      for (int i = 0; i < nclk; i++) begin
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         if (i < 10) cap[i] = ps2_data_in;
         if (i == 9 && keep) cap_q.push_back(cap);
         dev_clk = 1'b1;
         if (i == 9) dev_data = ack_bit;
         if (i == 10) dev_data = 1'b1;
         repeat (HALF) @(negedge clk);
      end
      dev_clk  = 1'b1;
      dev_data = 1'b1;
   endtask

   task automatic send(input logic [7:0] b, input bit to, input bit ackb);
      int n = 0;
      exp_t e;
      @(negedge clk);
      tx_valid = 1'b1;
      tx_data  = b;
      while (!tx_ready && n < 6000) begin @(negedge clk); n++; end
      if (!tx_ready) begin check("accept", 0, 1); tx_valid = 1'b0; return; end
      e.b = b; e.to = to; e.ack_bad = ackb;
      exp_q.push_back(e);
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (!tx_ready && n < 6000) begin @(negedge clk); n++; end
      if (!tx_ready) check("return_idle", 0, 1);
   endtask

   task automatic run_frame(input logic [7:0] b, input bit ackb);
      int att = (RETRY && ackb) ? 2 : 1;
      send(b, 1'b0, ackb);
      for (int a = 0; a < att; a++) device_frame(11, ackb, a == att - 1);
      wait_idle();
   endtask

   initial begin
      #(10 * 90000);
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int d0, n, s0;
      logic [7:0] rb;
      bit ra;
      repeat (3) @(negedge clk);
      check("rst_tx_ready", tx_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      check("rst_pulses", {done, ack_err, timeout_err}, 0);
      clrn = 1'b1;
      repeat (3) @(negedge clk);

      run_frame(CMD_SET_LED, 1'b0);
      run_frame(CMD_ENABLE, 1'b1);

      // no device clocks at all
      send(8'h00, 1'b1, 1'b0);
      wait_idle();

      // reset in the middle of a frame
      send(CMD_RESET, 1'b0, 1'b0);
      device_frame(4, 1'b0, 1'b0);
      check("busy_mid_frame", busy, 1);
      #3 clrn = 1'b0;
      #1;
      check("async_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      check("async_rst_ready", tx_ready, 1);
      check("async_rst_busy", busy, 0);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      @(negedge clk);
      clrn = 1'b1;
      repeat (3) @(negedge clk);
      run_frame(CMD_ENABLE, 1'b0);

      // request held during a frame
      send(CMD_SET_LED, 1'b0, 1'b0);
      tx_valid = 1'b1;
      tx_data  = 8'hAA;
      fork
         device_frame(11, 1'b0, 1'b1);
         begin
            exp_t e;
            d0 = done_cnt;
            n  = 0;
            while (!tx_ready && n < 6000) begin @(negedge clk); n++; end
            check("held_after_done", done_cnt, d0 + 1);
            e.b = 8'hAA; e.to = 1'b0; e.ack_bad = 1'b0;
            exp_q.push_back(e);
            @(negedge clk);
            tx_valid = 1'b0;
         end
      join
      device_frame(11, 1'b0, 1'b1);
      wait_idle();

`ifdef PS2_TX_RETRY_EN
      // first attempt NAKed, second good
      s0 = inh_starts;
      d0 = done_cnt;
      send(CMD_ENABLE, 1'b0, 1'b0);
      device_frame(11, 1'b1, 1'b0);
      device_frame(11, 1'b0, 1'b1);
      wait_idle();
      repeat (2) @(negedge clk);
      check("retry_inhibits", inh_starts - s0, 2);
      check("retry_single_done", done_cnt - d0, 1);
`else
      s0 = 0;
`endif

      for (int k = 0; k < 8; k++) begin
         rb = 8'($urandom_range(0, 255));
         ra = 1'($urandom_range(0, 1));
         run_frame(rb, ra);
      end

      repeat (5) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      check("invariants", inv_bad, 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte to the keyboard, for example 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset), using the request-to-send sequence, then checks the device ACK bit. It shares the ps2_clk/ps2_data lines with the existing keyboard receiver through open-drain enables, and sits beside that receiver under the keyboard top.

Parameters:
INHIBIT_CYCLES, 5000, clk cycles ps2_clk is held low for request-to-send (100 us at 50 MHz).
TIMEOUT_CYCLES, 1000000, max clk cycles from releasing ps2_clk to completion before abort (20 ms at 50 MHz).

Ports:
clk  in  1  system clock
clrn  in  1  asynchronous active-low reset
tx_valid  in  1  request to send tx_data
tx_data  in  8  command byte
tx_ready  out  1  high in IDLE; a byte is accepted on tx_valid&tx_ready
busy  out  1  high in any state except IDLE
done  out  1  1-cycle pulse when the frame completes, ACK good or bad
ack_err  out  1  1-cycle pulse coincident with done when the ACK bit read 1
timeout_err  out  1  1-cycle pulse on timeout abort; done does not pulse
ps2_clk_in  in  1  raw PS/2 clock line
ps2_data_in  in  1  raw PS/2 data line
ps2_clk_oe  out  1  1 = drive ps2_clk low, 0 = release
ps2_data_oe  out  1  1 = drive ps2_data low, 0 = release

Behaviour:
- Reset (clrn=0, async): state IDLE; tx_ready=1; busy=0; done=0; ack_err=0; timeout_err=0; ps2_clk_oe=0; ps2_data_oe=0; all counters and sync flops cleared, sync flops to 1. Reset mid-frame releases both lines immediately.
- Sync: 3-flop shift of ps2_clk_in. fall = sync[2] & ~sync[1]. ps2_data_in passes through 2 flops.
- Accept: on tx_valid&tx_ready, latch tx_data into shreg and parity = ~^tx_data (odd parity); go to INHIBIT next cycle. tx_valid while busy is ignored.
- INHIBIT: clk_oe=1 for INHIBIT_CYCLES cycles. Data_oe=1 is asserted in the last cycle of INHIBIT (start bit). Then go to REQ.
- REQ: clk_oe=0, data_oe=1; timeout counter starts. Wait for fall.
- DATA: on falling edges 1..8, data_oe = ~shreg[0], then shreg shifts right (LSB first). bitcnt counts 0..7.
- PARITY: on falling edge 9, data_oe = ~parity.
- STOP: on falling edge 10, data_oe=0 (line released, stop=1).
- ACK: on falling edge 11, sample synced data. 0 = good; 1 = ack_err is set for the done pulse.
- WAIT_IDLE: wait until the synced clk and data are both 1. Then pulse done (and ack_err if flagged) and return to IDLE. tx_ready rises the cycle after the done pulse.
- Timeout: if the counter reaches TIMEOUT_CYCLES in any state REQ..WAIT_IDLE, release both lines, pulse timeout_err and go to IDLE. The counter resets on every entry to REQ.
- Simultaneous events: a request during a device-to-host frame is legal. The inhibit aborts the device frame (standard host priority), and the receiver discards the partial frame by its own parity/count check.
- Widths: the inhibit and timeout counters are sized with $clog2 of their parameter and saturate; they never wrap.

Optional Feature:
PS2_TX_RETRY_EN. Defined: on ACK error or timeout, automatically re-run the same byte from INHIBIT once. done, ack_err and timeout_err pulse only after the final attempt; the 1-bit retry flag clears on IDLE. Undefined: no retry; errors are reported on the first failure.

Decomposition:
Shared package ps2_pkg holds:
- state localparams: IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, WAIT_IDLE
- command constants: CMD_SET_LED=0xED, CMD_ENABLE=0xF4, CMD_RESET=0xFF, RSP_ACK=0xFA, RSP_RESEND=0xFE, BREAK=0xF0

Sub-module ps2_sync: 3-flop clk synchroniser plus falling-edge pulse, reused by the receiver.

Test Plan:
- Bench parameters INHIBIT_CYCLES=20, TIMEOUT_CYCLES=2000. Send 0xED with the device model generating 11 clocks and ACK=0 -> clk_oe high exactly 20 cycles; device samples bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done pulses with ack_err=0.
- Send 0xF4 with a device that answers ACK=1 -> line bits 0,0,1,0,1,1,1,1, parity 0; done and ack_err pulse together.
- Send 0x00 with no device clocks -> timeout_err pulses 2000 cycles after REQ entry; both oe=0; no done pulse; tx_ready=1 next cycle.
- Assert clrn=0 after device falling edge 4 of an 0xFF send -> both oe drop asynchronously; tx_ready=1, busy=0; a new 0xF4 send then completes cleanly.
- Hold tx_valid with 0xAA during a 0xED frame -> not accepted until after the done pulse; then 0xAA is sent with parity 1.
- With PS2_TX_RETRY_EN defined, first ACK=1 and second ACK=0 -> two INHIBIT phases, a single done pulse, ack_err=0.
